// File: rtl/dqn_pkg.sv
// Shared definitions for the DQN replay memory.
//  - DATA_WIDTH / ACTION_WIDTH : transition field widths
//  - ENTRY_W and *_OFF         : layout of one stored transition
//                                {cs0, cs1, a, r, ns0, ns1, done}, done in bit 0
//  - state_t                   : replay FSM encodings
package dqn_pkg;
  localparam int DATA_WIDTH   = 32;
  localparam int ACTION_WIDTH = 2;
  localparam int ENTRY_W      = 5*DATA_WIDTH + ACTION_WIDTH + 1;

  localparam int DONE_OFF = 0;
  localparam int NS1_OFF  = 1;
  localparam int NS0_OFF  = NS1_OFF + DATA_WIDTH;
  localparam int R_OFF    = NS0_OFF + DATA_WIDTH;
  localparam int A_OFF    = R_OFF + DATA_WIDTH;
  localparam int CS1_OFF  = A_OFF + ACTION_WIDTH;
  localparam int CS0_OFF  = CS1_OFF + DATA_WIDTH;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PICK   = 3'd1,
    ST_READ   = 3'd2,
    ST_OUT    = 3'd3,
    ST_WAIT   = 3'd4,
    ST_UPDATE = 3'd5
  } state_t;
endpackage

// File: rtl/replay_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port with a
// registered read (data appears the cycle after re).
//  clk           clock
//  we/waddr/wdata write port
//  re/raddr      read request / address
//  rdata         registered read data
module replay_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/dqn_replay_memory.sv
// Experience-replay buffer. Transitions are written into a circular RAM while
// idle; an episode-end write with enough stored samples starts a training
// round that replays BATCH_SIZE transitions, one per i_main_net_done
// handshake, and ends with a one-cycle o_update_request.
// Ports:
//  clk, rst_n                  clock, async active-low reset
//  i_valid + i_* fields        transition write (dropped outside IDLE)
//  i_main_net_done             network consumed current sample
//  o_valid + o_* fields        sampled transition (o_valid one-cycle pulse)
//  o_train_mode                high for the whole round
//  o_update_request            one-cycle pulse at round end
//  o_ready_for_train           stored count >= TRAIN_START
// Build option: REPLAY_SEQ_SAMPLE_EN selects sequential sampling from the
// oldest entry instead of LFSR rejection sampling.
module dqn_replay_memory
  import dqn_pkg::*;
#(
  parameter int MEMORY_WIDTH = 10000,
  parameter int TRAIN_START  = 20,
  parameter int BATCH_SIZE   = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_valid,
  input  logic [DATA_WIDTH-1:0]   i_current_state_0,
  input  logic [DATA_WIDTH-1:0]   i_current_state_1,
  input  logic [ACTION_WIDTH-1:0] i_action,
  input  logic [DATA_WIDTH-1:0]   i_reward,
  input  logic [DATA_WIDTH-1:0]   i_next_state_0,
  input  logic [DATA_WIDTH-1:0]   i_next_state_1,
  input  logic                    i_done,
  input  logic                    i_main_net_done,
  output logic                    o_valid,
  output logic [DATA_WIDTH-1:0]   o_current_state_0,
  output logic [DATA_WIDTH-1:0]   o_current_state_1,
  output logic [ACTION_WIDTH-1:0] o_action,
  output logic [DATA_WIDTH-1:0]   o_reward,
  output logic [DATA_WIDTH-1:0]   o_next_state_0,
  output logic [DATA_WIDTH-1:0]   o_next_state_1,
  output logic                    o_done,
  output logic                    o_train_mode,
  output logic                    o_update_request,
  output logic                    o_ready_for_train
);
  localparam int IW = (MEMORY_WIDTH > 1) ? $clog2(MEMORY_WIDTH) : 1;
  localparam int CW = $clog2(MEMORY_WIDTH + 1);
  localparam int BW = $clog2(BATCH_SIZE + 1);

  state_t             state;
  logic [IW-1:0]      wr_ptr, ptr_inc, sel_idx, cand;
  logic [CW-1:0]      count, cnt_inc, cnt_nxt;
  logic [BW-1:0]      smp_cnt;
  logic               wr_en, pick_ok;
  logic [ENTRY_W-1:0] wr_data, rd_data;

  assign wr_en   = i_valid && (state == ST_IDLE);
  assign cnt_inc = (count == CW'(MEMORY_WIDTH)) ? count : count + 1'b1;
  assign cnt_nxt = wr_en ? cnt_inc : count;
  assign ptr_inc = (wr_ptr == IW'(MEMORY_WIDTH - 1)) ? '0 : wr_ptr + 1'b1;
  assign wr_data = {i_current_state_0, i_current_state_1, i_action, i_reward,
                    i_next_state_0, i_next_state_1, i_done};

  replay_ram #(.DEPTH(MEMORY_WIDTH), .WIDTH(ENTRY_W), .AW(IW)) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .re    (state == ST_READ),
    .raddr (sel_idx),
    .rdata (rd_data)
  );

`ifdef REPLAY_SEQ_SAMPLE_EN
  // seq_off is relative to the oldest valid entry, so the window slides with
  // overwrites once the buffer is full.
  logic [CW-1:0] seq_off;

  always_comb begin
    int old_i, idx_i;
    old_i = int'(wr_ptr) + MEMORY_WIDTH - int'(count);
    if (old_i >= MEMORY_WIDTH) old_i = old_i - MEMORY_WIDTH;
    idx_i = old_i + int'(seq_off);
    if (idx_i >= MEMORY_WIDTH) idx_i = idx_i - MEMORY_WIDTH;
    cand    = IW'(idx_i);
    pick_ok = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      seq_off <= '0;
    else if (state == ST_PICK)
      seq_off <= (seq_off + 1'b1 >= count) ? '0 : seq_off + 1'b1;
  end
`else
  // Galois LFSR, x^32+x^22+x^2+x+1, free-running; a rejected pick simply
  // retries next cycle with the advanced value.
  localparam logic [31:0] LFSR_SEED = 32'hACE1_2B7F;
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;
  logic [31:0] lfsr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= LFSR_SEED;
    else        lfsr <= {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_TAPS : 32'h0);
  end

  always_comb begin
    cand    = lfsr[IW-1:0];
    pick_ok = (CW'(cand) < count);
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= ST_IDLE;
      wr_ptr            <= '0;
      count             <= '0;
      sel_idx           <= '0;
      smp_cnt           <= '0;
      o_valid           <= 1'b0;
      o_current_state_0 <= '0;
      o_current_state_1 <= '0;
      o_action          <= '0;
      o_reward          <= '0;
      o_next_state_0    <= '0;
      o_next_state_1    <= '0;
      o_done            <= 1'b0;
      o_train_mode      <= 1'b0;
      o_update_request  <= 1'b0;
      o_ready_for_train <= 1'b0;
    end else begin
      o_valid           <= 1'b0;
      o_update_request  <= 1'b0;
      o_ready_for_train <= (cnt_nxt >= CW'(TRAIN_START));
      if (wr_en) begin
        wr_ptr <= ptr_inc;
        count  <= cnt_inc;
      end
      case (state)
        ST_IDLE:
          if (wr_en && i_done && (cnt_inc >= CW'(TRAIN_START))) begin
            state        <= ST_PICK;
            o_train_mode <= 1'b1;
          end
        ST_PICK:
          if (pick_ok) begin
            sel_idx <= cand;
            state   <= ST_READ;
          end
        ST_READ: state <= ST_OUT;
        ST_OUT: begin
          o_current_state_0 <= rd_data[CS0_OFF +: DATA_WIDTH];
          o_current_state_1 <= rd_data[CS1_OFF +: DATA_WIDTH];
          o_action          <= rd_data[A_OFF   +: ACTION_WIDTH];
          o_reward          <= rd_data[R_OFF   +: DATA_WIDTH];
          o_next_state_0    <= rd_data[NS0_OFF +: DATA_WIDTH];
          o_next_state_1    <= rd_data[NS1_OFF +: DATA_WIDTH];
          o_done            <= rd_data[DONE_OFF];
          o_valid           <= 1'b1;
          state             <= ST_WAIT;
        end
        ST_WAIT:
          if (i_main_net_done) begin
            smp_cnt <= smp_cnt + 1'b1;
            if (smp_cnt + 1'b1 == BW'(BATCH_SIZE)) begin
              state            <= ST_UPDATE;
              o_update_request <= 1'b1;
            end else begin
              state <= ST_PICK;
            end
          end
        ST_UPDATE: begin
          state        <= ST_IDLE;
          o_train_mode <= 1'b0;
          smp_cnt      <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dqn_replay_memory.sv
// Randomized self-checking bench for dqn_replay_memory (MEMORY_WIDTH=32).
// The reference keeps the stored transitions as a queue (oldest first,
// capped at capacity) and tracks whether a training round is open.
module tb_dqn_replay_memory;
  import dqn_pkg::*;

  localparam int MW = 32;
  localparam int TS = 20;
  localparam int BS = 2;
`ifdef REPLAY_SEQ_SAMPLE_EN
  localparam bit SEQ = 1'b1;
  localparam int NR  = 300;
`else
  localparam bit SEQ = 1'b0;
  localparam int NR  = 1000;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic i_valid, i_done, i_main_net_done;
  logic [DATA_WIDTH-1:0] i_current_state_0, i_current_state_1, i_reward;
  logic [DATA_WIDTH-1:0] i_next_state_0, i_next_state_1;
  logic [ACTION_WIDTH-1:0] i_action;
  logic o_valid, o_done, o_train_mode, o_update_request, o_ready_for_train;
  logic [DATA_WIDTH-1:0] o_current_state_0, o_current_state_1, o_reward;
  logic [DATA_WIDTH-1:0] o_next_state_0, o_next_state_1;
  logic [ACTION_WIDTH-1:0] o_action;

  always #5 clk = ~clk;

  dqn_replay_memory #(.MEMORY_WIDTH(MW), .TRAIN_START(TS), .BATCH_SIZE(BS)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid),
    .i_current_state_0(i_current_state_0), .i_current_state_1(i_current_state_1),
    .i_action(i_action), .i_reward(i_reward),
    .i_next_state_0(i_next_state_0), .i_next_state_1(i_next_state_1),
    .i_done(i_done), .i_main_net_done(i_main_net_done), .o_valid(o_valid),
    .o_current_state_0(o_current_state_0), .o_current_state_1(o_current_state_1),
    .o_action(o_action), .o_reward(o_reward),
    .o_next_state_0(o_next_state_0), .o_next_state_1(o_next_state_1),
    .o_done(o_done), .o_train_mode(o_train_mode),
    .o_update_request(o_update_request), .o_ready_for_train(o_ready_for_train)
  );

  typedef struct {
    logic [31:0] cs0, cs1, r, ns0, ns1;
    logic [1:0]  a;
    logic        d;
  } ent_t;

  ent_t q[$];
  int   off      = 0;
  bit   in_round = 1'b0;
  int   nvec     = 0;
  int   nerr     = 0;
  int   vld_cnt  = 0;
  int   wseq     = 0;

  always @(negedge clk) if (o_valid) vld_cnt++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; i_valid = 1'b0; i_done = 1'b0; i_main_net_done = 1'b0;
    q.delete(); off = 0; in_round = 1'b0;
    #12;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One write attempt; the model stores it only outside a round.
  task automatic wr(input logic [31:0] r, input logic d);
    ent_t e;
    e.cs0 = $urandom; e.cs1 = $urandom; e.ns0 = $urandom; e.ns1 = $urandom;
    e.a = 2'($urandom); e.r = r; e.d = d;
    i_current_state_0 = e.cs0; i_current_state_1 = e.cs1; i_action = e.a;
    i_reward = e.r; i_next_state_0 = e.ns0; i_next_state_1 = e.ns1; i_done = d;
    i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0; i_done = 1'b0;
    if (!in_round) begin
      q.push_back(e);
      if (q.size() > MW) void'(q.pop_front());
      if (d && q.size() >= TS) in_round = 1'b1;
    end
  endtask

  task automatic chk_sample();
    ent_t e;
    bit   found;
    found = 1'b0;
    if (SEQ) begin
      e = q[off];
      off = (off + 1) % q.size();
      found = 1'b1;
    end else begin
      foreach (q[i]) if (!found && q[i].r == o_reward) begin e = q[i]; found = 1'b1; end
      chk("smp_in_range", found, 1'b1);
    end
    if (found) begin
      chk("smp_reward", o_reward, e.r);
      chk("smp_cs0", o_current_state_0, e.cs0);
      chk("smp_cs1", o_current_state_1, e.cs1);
      chk("smp_act", o_action, e.a);
      chk("smp_ns0", o_next_state_0, e.ns0);
      chk("smp_ns1", o_next_state_1, e.ns1);
      chk("smp_done", o_done, e.d);
    end
  endtask

  // Entered #1 after the triggering write edge.
  task automatic run_round();
    int v0;
    int lat;
    bit got;
    v0 = vld_cnt;
    for (int s = 0; s < BS; s++) begin
      got = 1'b0;
      for (lat = 1; lat <= 300; lat++) begin
        @(posedge clk); #1;
        if (o_valid) begin got = 1'b1; break; end
      end
      chk("vld_timeout", got, 1'b1);
      if (got) begin
        if (SEQ) chk("smp_latency", lat, 3);
        chk_sample();
      end
      @(posedge clk); #1;
      chk("vld_pulse", o_valid, 1'b0);
      chk("tm_hold", o_train_mode, 1'b1);
      if (s == 0) begin
        wr(32'hDEAD_0000 + 32'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
        chk("drop_tm", o_train_mode, 1'b1);
        chk("drop_rdy", o_ready_for_train, q.size() >= TS);
      end
      i_main_net_done = 1'b1;
      @(posedge clk); #1;
      i_main_net_done = 1'b0;
    end
    chk("upd_pulse", o_update_request, 1'b1);
    chk("upd_tm", o_train_mode, 1'b1);
    @(posedge clk); #1;
    chk("upd_fall", o_update_request, 1'b0);
    chk("tm_fall", o_train_mode, 1'b0);
    chk("vld_per_round", vld_cnt - v0, BS);
    in_round = 1'b0;
  endtask

  task automatic wr_chk(input logic [31:0] r, input logic d);
    wr(r, d);
    chk("wr_tm", o_train_mode, in_round);
    chk("wr_rdy", o_ready_for_train, q.size() >= TS);
    if (in_round) run_round();
  endtask

  initial begin
    int n;
    logic d;
    // reset state
    do_reset();
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_tm", o_train_mode, 1'b0);
    chk("rst_upd", o_update_request, 1'b0);
    chk("rst_rdy", o_ready_for_train, 1'b0);
    chk("rst_reward", o_reward, 32'h0);
    chk("rst_cs0", o_current_state_0, 32'h0);
    chk("rst_act", o_action, 2'h0);
    chk("rst_done", o_done, 1'b0);

    // done pulse while idle is ignored
    i_main_net_done = 1'b1; @(posedge clk); #1; i_main_net_done = 1'b0;
    chk("idle_netdone", o_train_mode, 1'b0);

    // 19 writes, episode end too early; 20th arms ready; 21st triggers
    for (int k = 0; k < 19; k++) wr_chk(32'(k), k == 18);
    wr_chk(32'd19, 1'b0);
    chk("ready_at_20", o_ready_for_train, 1'b1);
    wr_chk(32'd20, 1'b1);
    wr_chk(32'd21, 1'b1);
    wseq = 22;

    // random traffic
    repeat (NR) begin
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        d = (k == n - 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
        wr_chk(32'(wseq), d);
        wseq++;
      end
      if ($urandom_range(0, 7) == 0) begin
        i_main_net_done = 1'b1; @(posedge clk); #1; i_main_net_done = 1'b0;
        chk("idle_netdone", o_train_mode, 1'b0);
      end
    end

    // wrap: 40 writes into 32 entries, oldest is reward 8
    do_reset();
    for (int k = 0; k < 39; k++) wr_chk(32'(k), 1'b0);
    wr(32'd39, 1'b1);
    chk("wrap_tm", o_train_mode, 1'b1);
    chk("wrap_oldest", q[0].r, 32'd8);
    run_round();

    // reset in WAIT aborts the round
    do_reset();
    for (int k = 0; k < 19; k++) wr(32'(k), 1'b0);
    wr(32'd19, 1'b1);
    chk("abort_tm", o_train_mode, 1'b1);
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 300 && !got; c++) begin
        @(posedge clk); #1;
        got = o_valid;
      end
      chk("abort_vld", got, 1'b1);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("arst_tm", o_train_mode, 1'b0);
    chk("arst_valid", o_valid, 1'b0);
    chk("arst_reward", o_reward, 32'h0);
    chk("arst_rdy", o_ready_for_train, 1'b0);
    chk("arst_upd", o_update_request, 1'b0);
    q.delete(); off = 0; in_round = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_tm", o_train_mode, 1'b0);
    chk("post_rst_rdy", o_ready_for_train, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
